// File: rtl/mux_nto1_scan_pkg.sv
// Shared constants and state encoding for the N-to-1 scanning multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

endpackage

// File: rtl/mux_nto1_scan_if.sv
// Bus between the channel sources / consumer and the N-to-1 scanning multiplexer.
interface mux_nto1_scan_if #(
    parameter int N = 4,
    parameter int W = 1
);
    localparam int SEL_W = $clog2(N);

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel_in;
    logic [N*W-1:0]     d;
    logic [W-1:0]       y;
    logic [SEL_W-1:0]   sel_out;
    logic               valid;
    logic               wrap;

    modport master (
        output en, mode, sel_in, d,
        input  y, sel_out, valid, wrap
    );

    modport slave (
        input  en, mode, sel_in, d,
        output y, sel_out, valid, wrap
    );
endinterface

// File: rtl/mux_nto1_scan_counter.sv
// Channel/dwell counter for scan mode. A clear makes the current position
// channel 0 / dwell 0 in the same cycle, so the entry cycle is the first
// dwell cycle of channel 0 and the stored position is already one step on.
module scan_counter #(
    parameter  int N     = 4,
    parameter  int DWELL = 4,
    localparam int CH_W  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_adv,
    output logic [CH_W-1:0] o_ch,
    output logic            o_wrap
);
    localparam int DC_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CH_W-1:0] r_ch;
    logic [DC_W-1:0] r_dc;
    logic [CH_W-1:0] w_ch_cur;
    logic [CH_W-1:0] w_ch_nxt;
    logic [DC_W-1:0] w_dc_cur;
    logic [DC_W-1:0] w_dc_nxt;
    logic            w_step;
    logic            w_last_dwell;
    logic            w_last_ch;

    // Current position (cleared view on entry) and the step that follows it.
    always_comb begin
        w_step       = i_clear | i_adv;
        w_ch_cur     = i_clear ? '0 : r_ch;
        w_dc_cur     = i_clear ? '0 : r_dc;
        w_last_dwell = (w_dc_cur == DC_W'(DWELL - 1));
        w_last_ch    = (w_ch_cur == CH_W'(N - 1));
        w_dc_nxt     = w_last_dwell ? '0 : w_dc_cur + DC_W'(1);
        if (w_last_dwell)
            w_ch_nxt = w_last_ch ? '0 : w_ch_cur + CH_W'(1);
        else
            w_ch_nxt = w_ch_cur;
        o_ch   = w_ch_cur;
        o_wrap = w_step & w_last_dwell & w_last_ch;
    end

    // Position only moves while scanning; otherwise it holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch <= '0;
            r_dc <= '0;
        end else if (w_step) begin
            r_ch <= w_ch_nxt;
            r_dc <= w_dc_nxt;
        end
    end
endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 multiplexer with manual select and auto-scan modes.
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    mux_nto1_scan_if.slave bus
);
    state_t           r_state;
    logic [W-1:0]     r_y;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic             r_wrap;

    logic             w_scan_req;
    logic             w_clear;
    logic             w_adv;
    logic [SEL_W-1:0] w_ch;
    logic             w_wrap;
    logic             w_man_ok;
    logic [W-1:0]     w_man_y;
    logic [W-1:0]     w_scan_y;

    // Scan requests and channel data selection via indexed part-selects.
    always_comb begin
        w_scan_req = bus.en && (bus.mode == MODE_SCAN);
        w_clear    = w_scan_req && (r_state != ST_SCAN);
        w_adv      = w_scan_req && (r_state == ST_SCAN);
        w_man_ok   = (int'(bus.sel_in) < N);
        w_man_y    = w_man_ok ? bus.d[int'(bus.sel_in)*W +: W] : '0;
        w_scan_y   = bus.d[int'(w_ch)*W +: W];
    end

    scan_counter #(
        .N     (N),
        .DWELL (DWELL)
    ) u_scan_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_adv   (w_adv),
        .o_ch    (w_ch),
        .o_wrap  (w_wrap)
    );

    // State machine and registered outputs; disable wins over any wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!bus.en) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (bus.mode == MODE_MANUAL) begin
            r_state <= ST_MAN;
            r_y     <= w_man_y;
            r_sel   <= bus.sel_in;
            r_valid <= w_man_ok;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= ST_SCAN;
            r_y     <= w_scan_y;
            r_sel   <= w_ch;
            r_valid <= 1'b1;
            r_wrap  <= w_wrap;
        end
    end

    assign bus.y       = r_y;
    assign bus.sel_out = r_sel;
    assign bus.valid   = r_valid;
    assign bus.wrap    = r_wrap;
endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: two instances (N=4/W=1/DWELL=2, N=5/W=8/DWELL=3)
// checked every cycle against a cycle-count model, plus directed literals.
module tb_mux_nto1_scan;
    logic clk;
    logic rst;

    int errors;
    int checks;

    mux_nto1_scan_if #(.N(4), .W(1)) ifa ();
    mux_nto1_scan_if #(.N(5), .W(8)) ifb ();

    mux_nto1_scan #(.N(4), .W(1), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mux_nto1_scan #(.N(5), .W(8), .DWELL(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          armed;
        bit          scanning;
        int          t;
        logic [63:0] y;
        int          sel;
        bit          valid;
        bit          wrap;
    } mst_t;

    mst_t ma;
    mst_t mb;

    // Model: scan position is simply the number of scan cycles since entry.
    function automatic mst_t mstep(mst_t s, bit r, bit en, bit mode, int sel_in,
                                   logic [63:0] d, int n, int w, int dw);
        mst_t o;
        logic [63:0] mask;
        int ch;
        o = s;
        mask = (64'd1 << w) - 64'd1;
        if (r) begin
            o.armed = 1; o.scanning = 0; o.t = 0;
            o.y = '0; o.sel = 0; o.valid = 0; o.wrap = 0;
        end else if (!o.armed) begin
            o = s;
        end else if (!en) begin
            o.scanning = 0; o.valid = 0; o.wrap = 0;
        end else if (!mode) begin
            o.scanning = 0; o.wrap = 0; o.sel = sel_in;
            if (sel_in < n) begin
                o.y = (d >> (sel_in * w)) & mask;
                o.valid = 1;
            end else begin
                o.y = '0;
                o.valid = 0;
            end
        end else begin
            o.t = s.scanning ? s.t + 1 : 0;
            o.scanning = 1;
            ch = (o.t / dw) % n;
            o.y = (d >> (ch * w)) & mask;
            o.sel = ch;
            o.valid = 1;
            o.wrap = ((o.t % (n * dw)) == (n * dw - 1));
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ma = mstep(ma, rst, ifa.en, ifa.mode, int'(ifa.sel_in), 64'(ifa.d), 4, 1, 2);
        mb = mstep(mb, rst, ifb.en, ifb.mode, int'(ifb.sel_in), 64'(ifb.d), 5, 8, 3);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (ma.armed) begin
            chk("A.y",     64'(ifa.y),       ma.y);
            chk("A.sel",   64'(ifa.sel_out), 64'(ma.sel));
            chk("A.valid", 64'(ifa.valid),   64'(ma.valid));
            chk("A.wrap",  64'(ifa.wrap),    64'(ma.wrap));
        end
        if (mb.armed) begin
            chk("B.y",     64'(ifb.y),       mb.y);
            chk("B.sel",   64'(ifb.sel_out), 64'(mb.sel));
            chk("B.valid", 64'(ifb.valid),   64'(mb.valid));
            chk("B.wrap",  64'(ifb.wrap),    64'(mb.wrap));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lit_a(input string nm, input logic [63:0] y, input logic [63:0] sel,
                         input bit v, input bit wr);
        chk({nm, ".y"},     64'(ifa.y),       y);
        chk({nm, ".sel"},   64'(ifa.sel_out), sel);
        chk({nm, ".valid"}, 64'(ifa.valid),   64'(v));
        chk({nm, ".wrap"},  64'(ifa.wrap),    64'(wr));
    endtask

    task automatic lit_b(input string nm, input logic [63:0] y, input logic [63:0] sel,
                         input bit v, input bit wr);
        chk({nm, ".y"},     64'(ifb.y),       y);
        chk({nm, ".sel"},   64'(ifb.sel_out), sel);
        chk({nm, ".valid"}, 64'(ifb.valid),   64'(v));
        chk({nm, ".wrap"},  64'(ifb.wrap),    64'(wr));
    endtask

    int exp_man[4] = '{1, 0, 1, 1};
    int scan_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        errors = 0;
        checks = 0;
        ma = '{default: 0};
        mb = '{default: 0};
        rst = 1'b1;
        ifa.en = 1'b0; ifa.mode = 1'b0; ifa.sel_in = '0; ifa.d = '0;
        ifb.en = 1'b0; ifb.mode = 1'b0; ifb.sel_in = '0; ifb.d = '0;

        tick();
        tick();
        lit_a("rst_a", 0, 0, 0, 0);
        lit_b("rst_b", 0, 0, 0, 0);
        rst = 1'b0;

        // Manual select over d=1101.
        ifa.en = 1'b1; ifa.mode = 1'b0; ifa.d = 4'b1101;
        for (int s = 0; s < 4; s++) begin
            ifa.sel_in = 2'(s);
            tick();
            lit_a("man", 64'(exp_man[s]), 64'(s), 1, 0);
        end

        // Switch to scan with sel_in=3 still applied.
        ifa.mode = 1'b1; ifa.d = 4'b0100;
        for (int i = 0; i < 9; i++) begin
            tick();
            lit_a("scan", (scan_seq[i] == 2) ? 64'd1 : 64'd0, 64'(scan_seq[i]), 1, (i == 7));
        end

        // Run on to channel 2, then drop enable for 3 cycles.
        for (int i = 0; i < 4; i++) tick();
        lit_a("at_ch2", 1, 2, 1, 0);
        ifa.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit_a("gap", 1, 2, 0, 0);
        end
        ifa.en = 1'b1;
        tick();
        lit_a("reentry0", 0, 0, 1, 0);
        tick();
        lit_a("reentry1", 0, 0, 1, 0);
        tick();
        lit_a("reentry2", 0, 1, 1, 0);

        // Reset mid-scan with enable held high.
        ifa.d = 4'b1111;
        tick();
        lit_a("pre_rst", 1, 1, 1, 0);
        rst = 1'b1;
        tick();
        lit_a("mid_rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        lit_a("post_rst", 1, 0, 1, 0);
        ifa.en = 1'b0;

        // N=5, W=8 manual: out-of-range and in-range selects.
        ifb.en = 1'b1; ifb.mode = 1'b0;
        ifb.d = {8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};
        ifb.sel_in = 3'd6;
        tick();
        lit_b("b_sel6", 0, 6, 0, 0);
        ifb.sel_in = 3'd4;
        tick();
        lit_b("b_sel4", 64'hA5, 4, 1, 0);
        ifb.sel_in = 3'd5;
        tick();
        lit_b("b_sel5", 0, 5, 0, 0);
        ifb.sel_in = 3'd1;
        tick();
        lit_b("b_sel1", 64'h22, 1, 1, 0);

        // N=5 scan with a data change in mid-dwell, then disable on the wrap cycle.
        ifb.mode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 3) ifb.d[15:8] = 8'h77;
            if (i == 4) lit_b("b_midchg", 64'h77, 1, 1, 0);
        end
        lit_b("b_t13", 64'hA5, 4, 1, 0);
        ifb.en = 1'b0;
        tick();
        lit_b("b_en_wins", 64'hA5, 4, 0, 0);
        ifb.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("b_sweep.sel", 64'(ifb.sel_out), 64'((i / 3) % 5));
            chk("b_sweep.wrap", 64'(ifb.wrap), 64'(i == 14));
        end
        ifb.en = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
